// File: rtl/gol_window_gen.sv
// Streams a row-major board and emits, per cell, the registered 3x3 neighbourhood
// consumed by GOLNode, using a scan with an internal zero pad row and column.
module gol_window_gen #(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_cell,
    output logic       in_ready,
    output logic       out_valid,
    output logic [8:0] out_win,
    output logic       out_last
);
    localparam int CW = $clog2(W + 1);
    localparam int RW = $clog2(H + 1);
    localparam int L  = 2 * W + 5;
    localparam logic [CW-1:0] COL_PAD = CW'(W);
    localparam logic [RW-1:0] ROW_PAD = RW'(H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [L-1:0]  sr;
    logic [L-1:0]  sr_next;
    logic          pad;
    logic          shift_en;
    logic          shift_bit;
    logic          emit;
    logic [8:0]    taps;

    // Handshake: a cell transfers on a posedge where in_valid && in_ready are both
    // high; in_ready depends only on the scan position and reset, never on in_valid.
    always_comb begin
        pad       = (col == COL_PAD) || (row == ROW_PAD);
        in_ready  = reset && !pad;
        shift_en  = pad || (in_valid && in_ready);
        shift_bit = pad ? 1'b0 : in_cell;
        sr_next   = {sr[L-2:0], shift_bit};
        emit      = shift_en && (row != '0) && (col != '0);
        // The row stride is W+1 because each row carries one pad column.
        taps      = {sr_next[2*W+4], sr_next[2*W+3], sr_next[2*W+2],
                     sr_next[W+3],   sr_next[W+2],   sr_next[W+1],
                     sr_next[2],     sr_next[1],     sr_next[0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            sr  <= '0;
        end else if (shift_en) begin
            sr <= sr_next;
            if (col == COL_PAD) begin
                col <= '0;
                row <= (row == ROW_PAD) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
        end else begin
            out_valid <= emit;
            out_last  <= emit && (row == ROW_PAD) && (col == COL_PAD);
            if (emit) begin
                out_win <= taps;
            end
        end
    end

endmodule

// File: tb/tb_gol_window_gen.sv
// Bench for gol_window_gen on a 4x4 board: windows are checked against a
// neighbourhood model computed directly from the board contents.
module tb_gol_window_gen;
    localparam int BW = 4;
    localparam int BH = 4;
    localparam int N  = BW * BH;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_cell = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] out_win;
    logic       out_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       last_q[$];
    int         wcyc_q[$];
    int         acc_cyc[N];

    gol_window_gen #(.W(BW), .H(BH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_cell(in_cell),
        .in_ready(in_ready), .out_valid(out_valid), .out_win(out_win), .out_last(out_last)
    );

    // clock and cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_q.push_back(out_win);
            last_q.push_back(out_last);
            wcyc_q.push_back(cyc);
        end
    end

    // reference neighbourhood of centre (r, c); off-board cells are dead
    function automatic logic [8:0] ref_win(input logic [N-1:0] cells, input int r, input int c);
        logic [8:0] w;
        w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr;
                int cc;
                rr = r + dr;
                cc = c + dc;
                if (rr >= 0 && rr < BH && cc >= 0 && cc < BW)
                    w[8 - ((dr + 1) * 3 + (dc + 1))] = cells[rr * BW + cc];
            end
        end
        return w;
    endfunction

    task automatic build_exp(input logic [N-1:0] cells);
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++)
                exp_q.push_back(ref_win(cells, r, c));
    endtask

    task automatic flush_queues();
        exp_q.delete();
        got_q.delete();
        last_q.delete();
        wcyc_q.delete();
    endtask

    // Streams one frame starting at a negedge; returns at the negedge where the
    // scan has wrapped back to (0,0), so the next frame can follow immediately.
    task automatic drive_frame(input logic [N-1:0] cells, input int gap_pct,
                               output int not_ready, output int cycles);
        int idx;
        idx = 0;
        not_ready = 0;
        cycles = 0;
        forever begin
            if (idx == N && in_ready) break;
            if (cycles > 2000) begin
                $display("FAIL drive_timeout got idx=%0d need %0d", idx, N);
                errors++;
                break;
            end
            in_valid = (idx < N) && ($urandom_range(99, 0) >= gap_pct);
            in_cell  = (idx < N) ? cells[idx] : 1'b0;
            if (!in_ready) not_ready++;
            if (in_valid && in_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            cycles++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_cell  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            $display("FAIL reset_flags got valid=%b last=%b need 0/0", out_valid, out_last);
            errors++;
        end
        checks++;
        if (out_win !== 9'h000) begin
            $display("FAIL reset_win got %h need 000", out_win);
            errors++;
        end
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_ready got %b need 0", in_ready);
            errors++;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL release_ready got %b need 1", in_ready);
            errors++;
        end
    endtask

    task automatic test_single_cell();
        int nr;
        int cy;
        int n_last;
        int last_pos;
        logic [N-1:0] cells;
        cells = '0;
        cells[0] = 1'b1;
        flush_queues();
        build_exp(cells);
        drive_frame(cells, 0, nr, cy);
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != N) begin
            $display("FAIL single_count got %0d need %0d", got_q.size(), N);
            errors++;
        end
        checks++;
        if (cy != (BH + 1) * (BW + 1)) begin
            $display("FAIL single_throughput got %0d need %0d", cy, (BH + 1) * (BW + 1));
            errors++;
        end
        if (got_q.size() == N) begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    $display("FAIL single_win[%0d] got %h need %h", i, got_q[i], exp_q[i]);
                    errors++;
                end
            end
            checks++;
            if (got_q[0] !== 9'h010 || got_q[1] !== 9'h020 || got_q[4] !== 9'h080 || got_q[5] !== 9'h100) begin
                $display("FAIL single_corner got %h %h %h %h need 010 020 080 100",
                         got_q[0], got_q[1], got_q[4], got_q[5]);
                errors++;
            end
            checks++;
            if (wcyc_q[0] - acc_cyc[BW + 1] != 1) begin
                $display("FAIL single_latency got %0d need 1", wcyc_q[0] - acc_cyc[BW + 1]);
                errors++;
            end
        end
        n_last = 0;
        last_pos = -1;
        foreach (last_q[i]) if (last_q[i]) begin n_last++; last_pos = i; end
        checks++;
        if (n_last != 1 || last_pos != N - 1) begin
            $display("FAIL single_last got n=%0d pos=%0d need n=1 pos=%0d", n_last, last_pos, N - 1);
            errors++;
        end
    endtask

    task automatic test_all_ones();
        int nr;
        int cy;
        flush_queues();
        build_exp('1);
        drive_frame('1, 0, nr, cy);
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != N) begin
            $display("FAIL ones_count got %0d need %0d", got_q.size(), N);
            errors++;
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    $display("FAIL ones_win[%0d] got %h need %h", i, got_q[i], exp_q[i]);
                    errors++;
                end
            end
            checks++;
            if (got_q[0] !== 9'h01B || got_q[1] !== 9'h03F || got_q[5] !== 9'h1FF ||
                got_q[15] !== 9'h1B0 || got_q[12] !== 9'h0D8) begin
                $display("FAIL ones_known got %h %h %h %h %h need 01b 03f 1ff 1b0 0d8",
                         got_q[0], got_q[1], got_q[5], got_q[15], got_q[12]);
                errors++;
            end
        end
    endtask

    task automatic test_stalls();
        int nr;
        int cy;
        for (int f = 0; f < 3; f++) begin
            flush_queues();
            build_exp('1);
            drive_frame('1, 40, nr, cy);
            repeat (2) @(negedge clk);
            checks++;
            if (nr != BH + BW + 1) begin
                $display("FAIL stall_not_ready[%0d] got %0d need %0d", f, nr, BH + BW + 1);
                errors++;
            end
            checks++;
            if (got_q.size() != N) begin
                $display("FAIL stall_count[%0d] got %0d need %0d", f, got_q.size(), N);
                errors++;
            end else begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        $display("FAIL stall_win[%0d][%0d] got %h need %h", f, i, got_q[i], exp_q[i]);
                        errors++;
                    end
                end
            end
        end
    endtask

    task automatic test_frame_isolation();
        int nr;
        int cy;
        int n_last;
        flush_queues();
        build_exp('1);
        build_exp('0);
        drive_frame('1, 0, nr, cy);
        drive_frame('0, 0, nr, cy);
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != 2 * N) begin
            $display("FAIL iso_count got %0d need %0d", got_q.size(), 2 * N);
            errors++;
        end else begin
            for (int i = 0; i < 2 * N; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    $display("FAIL iso_win[%0d] got %h need %h", i, got_q[i], exp_q[i]);
                    errors++;
                end
            end
            n_last = 0;
            foreach (last_q[i]) if (last_q[i]) n_last++;
            checks++;
            if (n_last != 2 || last_q[N - 1] !== 1'b1 || last_q[2 * N - 1] !== 1'b1) begin
                $display("FAIL iso_last got n=%0d need 2 at %0d and %0d", n_last, N - 1, 2 * N - 1);
                errors++;
            end
        end
    endtask

    task automatic test_mid_reset();
        int acc;
        int nr;
        int cy;
        logic [N-1:0] cells;
        acc = 0;
        while (acc < 7) begin
            in_valid = 1'b1;
            in_cell  = 1'b1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        // the seventh cell is (1,2), whose shift emits centre (0,1)
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL midrst_pre_valid got %b need 1", out_valid);
            errors++;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_win !== 9'h000 || in_ready !== 1'b0) begin
            $display("FAIL midrst_drop got valid=%b win=%h ready=%b need 0/000/0",
                     out_valid, out_win, in_ready);
            errors++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        flush_queues();
        cells = '0;
        cells[0] = 1'b1;
        build_exp(cells);
        drive_frame(cells, 20, nr, cy);
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != N) begin
            $display("FAIL midrst_count got %0d need %0d", got_q.size(), N);
            errors++;
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    $display("FAIL midrst_win[%0d] got %h need %h", i, got_q[i], exp_q[i]);
                    errors++;
                end
            end
            checks++;
            if (last_q[N - 1] !== 1'b1) begin
                $display("FAIL midrst_last got %b need 1", last_q[N - 1]);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_all_ones();
        test_stalls();
        test_frame_isolation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gol_window_gen.md
# gol_window_gen

- Upstream feeder for the Game-of-Life cell evaluator (`GOLNode`). Takes a board streamed row-major, one cell per accepted beat.
- Emits, for every board cell in the same row-major order, the registered 9-bit 3x3 neighbourhood that `GOLNode` consumes.
- Cells outside the board read as dead (0).
- Built from a zero-initialised shift-register window plus row/column scan counters that insert internal padding beats.

## Interface
- `W`, default 8: board width in cells, W >= 2.
- `H`, default 8: board height in cells, H >= 2.

- `clk`       in   1  single clock; all state updates on posedge.
- `reset`     in   1  asynchronous, active-low reset.
- `in_valid`  in   1  `in_cell` holds a board cell.
- `in_cell`   in   1  cell state, 1 = live.
- `in_ready`  out  1  block accepts a cell this cycle.
- `out_valid` out  1  `out_win` holds a window; one-cycle pulse per window.
- `out_win`   out  9  neighbourhood of the current centre cell (bit map below).
- `out_last`  out  1  qualifies `out_valid`: window of centre (H-1, W-1), the last one of the frame.

## Operation
- **Scan position (r, c).**
  - Ranges: r in 0..H, c in 0..W, row-major.
  - Wraps from (H, W) to (0, 0).
  - Counter width is $clog2(W+1) and $clog2(H+1).
- **Real position** (r < H and c < W):
  - `in_ready` = 1.
  - Advances only on `in_valid && in_ready`, shifting `in_cell` in.
  - With `in_valid` = 0, nothing changes.
- **Pad position** (r == H or c == W):
  - `in_ready` = 0.
  - Shifts in 0 and advances unconditionally every cycle.
  - There are H+W+1 pad positions per frame.
- **Shift register.**
  - Holds the current value plus the previous 2W+4 values.
  - Taps at ages k = {2W+4, 2W+3, 2W+2, W+3, W+2, W+1, 2, 1, 0} map to `out_win[8:0]` in that order.
  - Bit map: `[8]`=NW, `[7]`=N, `[6]`=NE, `[5]`=W, `[4]`=centre, `[3]`=E, `[2]`=SW, `[1]`=S, `[0]`=SE.
- **Emission.**
  - A shift at position (r, c) with r >= 1 and c >= 1 emits the window centred on (r-1, c-1).
  - Exactly H*W windows are emitted per frame, in row-major centre order.
- **Boundaries** need no masking:
  - Left and right neighbours at the edges come from the zero pad column.
  - The row above centre row 0 comes from the previous frame's pad row H, or from the reset zeros.
  - The row below centre row H-1 comes from pad row H.
- **Back-to-back frames:** the next frame's cell (0,0) is accepted as soon as the scan wraps. There is no leakage between frames.
- **Reset (asynchronous, any time, including mid-frame):**
  - Counters go to (0,0); shift register and all output registers are cleared.
  - `in_ready` = 0 while `reset` is low.
  - The first cell accepted after release is (0,0) of a fresh frame.

## Timing
- **Reset values:** `out_valid` = 0, `out_win` = 9'h000, `out_last` = 0, `in_ready` = 0.
- **`in_ready`:** combinational from the scan counters (and reset) only; it never depends on `in_valid`.
- **Output registers:**
  - `out_win`, `out_valid` and `out_last` are updated on the same posedge that performs the emitting shift.
  - They are valid the following cycle and held for exactly one cycle.
  - With `in_valid` held high, the latency from accepting cell (r+1, c+1) to its centre window (r, c) is 1 cycle.
- **Outputs low between windows:**
  - `out_valid` = 0 on every non-emitting cycle, including input stalls.
  - `out_win` is don't-care when `out_valid` = 0.
- **Throughput:** with `in_valid` held high, one frame takes (H+1)(W+1) cycles.
- **Window order:** identical regardless of `in_valid` gaps.

## Test plan
- **Reset.** Hold `reset` low, then release.
  - While low: `out_valid`/`out_last`/`out_win` = 0/0/9'h000 and `in_ready` = 0.
  - One cycle after release: `in_ready` = 1.
- **Single live cell, W=H=4.** Only cell (0,0) = 1.
  - Windows: centre (0,0) = 9'h010, (0,1) = 9'h020, (1,0) = 9'h080, (1,1) = 9'h100; the other 12 windows are 9'h000.
  - 16 `out_valid` pulses; `out_last` only on the 16th.
- **All-ones frame, W=H=4.**
  - Centre (0,0) = 9'h01B, (0,1) = 9'h03F, (1,1) = 9'h1FF, (3,3) = 9'h1B0, (3,0) = 9'h0D8.
- **Stalls.** Randomised `in_valid` gaps on the all-ones frame.
  - Window sequence is identical to the unstalled run.
  - `in_ready` = 0 on exactly 9 beats per frame, at c == 4 or r == 4.
- **Frame isolation.** All-ones frame immediately followed by an all-zeros frame.
  - All 16 second-frame windows = 9'h000; `out_last` pulses once per frame.
- **Mid-frame reset.** Pulse `reset` low after 7 accepted cells, then stream the single-live-cell frame.
  - `out_valid` drops immediately.
  - The post-reset windows exactly match the single-live-cell scenario.
